// File: rtl/reorder_buffer_mc_pkg.sv
// Shared default widths and per-entry status flags for the multi-CDB reorder buffer.
package reorder_buffer_mc_pkg;

    localparam int unsigned DEF_ROB_DEPTH = 16;
    localparam int unsigned DEF_ROB_W     = 4;
    localparam int unsigned DEF_NUM_CDB   = 2;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_REG_W     = 5;

    typedef struct packed {
        logic busy;
        logic ready;
        logic is_jump;
        logic is_store;
        logic pred_taken;
        logic taken;
    } rob_flags_t;

endpackage

// File: rtl/rob_cdb_bypass.sv
// Operand lookup: NUM_CDB-way id match against this cycle's writebacks, lowest channel wins,
// falling back to the stored entry.
module rob_cdb_bypass
    import reorder_buffer_mc_pkg::*;
#(
    parameter int unsigned NUM_CDB = DEF_NUM_CDB,
    parameter int unsigned ROB_W   = DEF_ROB_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic [ROB_W-1:0]          i_q_id,
    input  logic [NUM_CDB-1:0]        i_cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  i_cdb_id,
    input  logic [NUM_CDB*DATA_W-1:0] i_cdb_data,
    input  logic                      i_entry_ready,
    input  logic [DATA_W-1:0]         i_entry_data,
    output logic                      o_rdy,
    output logic [DATA_W-1:0]         o_data
);

    logic w_hit;

    always_comb begin
        w_hit  = 1'b0;
        o_rdy  = i_entry_ready;
        o_data = i_entry_ready ? i_entry_data : '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!w_hit && i_cdb_valid[k] && (i_cdb_id[k*ROB_W +: ROB_W] == i_q_id)) begin
                w_hit  = 1'b1;
                o_rdy  = 1'b1;
                o_data = i_cdb_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order commit reorder buffer with NUM_CDB writeback channels, operand bypass,
// store-commit signalling and misprediction flush/redirect.
module reorder_buffer_mc
    import reorder_buffer_mc_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int unsigned ROB_W     = $clog2(ROB_DEPTH),
    parameter int unsigned NUM_CDB   = DEF_NUM_CDB,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned REG_W     = DEF_REG_W
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      alloc_valid_in,
    input  logic [REG_W-1:0]          alloc_rd_in,
    input  logic                      alloc_is_jump_in,
    input  logic                      alloc_is_store_in,
    input  logic                      alloc_pred_taken_in,
    input  logic [ADDR_W-1:0]         alloc_pc_in,
    input  logic [ADDR_W-1:0]         alloc_rollback_pc_in,
    output logic [ROB_W-1:0]          alloc_id_out,
    output logic                      full_out,
    input  logic [ROB_W-1:0]          q1_id_in,
    input  logic [ROB_W-1:0]          q2_id_in,
    output logic                      q1_rdy_out,
    output logic                      q2_rdy_out,
    output logic [DATA_W-1:0]         q1_data_out,
    output logic [DATA_W-1:0]         q2_data_out,
    input  logic [NUM_CDB-1:0]        cdb_valid_in,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_id_in,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data_in,
    input  logic [NUM_CDB-1:0]        cdb_taken_in,
    output logic                      commit_valid_out,
    output logic [ROB_W-1:0]          commit_id_out,
    output logic [REG_W-1:0]          commit_rd_out,
    output logic [DATA_W-1:0]         commit_data_out,
    output logic                      commit_store_out,
    output logic                      pred_upd_valid_out,
    output logic                      pred_upd_taken_out,
    output logic [ADDR_W-1:0]         pred_upd_pc_out,
    output logic                      flush_out,
    output logic [ADDR_W-1:0]         flush_pc_out
);

    logic [ROB_W-1:0]  r_head;
    logic [ROB_W-1:0]  r_tail;
    logic [ROB_W:0]    r_count;
    rob_flags_t        r_flags [ROB_DEPTH];
    logic [REG_W-1:0]  r_rd    [ROB_DEPTH];
    logic [ADDR_W-1:0] r_pc    [ROB_DEPTH];
    logic [ADDR_W-1:0] r_rb_pc [ROB_DEPTH];
    logic [DATA_W-1:0] r_data  [ROB_DEPTH];

    logic              r_commit_valid;
    logic [ROB_W-1:0]  r_commit_id;
    logic [REG_W-1:0]  r_commit_rd;
    logic [DATA_W-1:0] r_commit_data;
    logic              r_commit_store;
    logic              r_pred_upd_valid;
    logic              r_pred_upd_taken;
    logic [ADDR_W-1:0] r_pred_upd_pc;
    logic              r_flush;
    logic [ADDR_W-1:0] r_flush_pc;

    rob_flags_t w_head;
    logic       w_full;
    logic       w_alloc;
    logic       w_commit;
    logic       w_mispredict;

    assign w_head       = r_flags[r_head];
    assign w_full       = (r_count == (ROB_W+1)'(ROB_DEPTH));
    assign w_alloc      = alloc_valid_in && !w_full;
    assign w_commit     = w_head.busy && w_head.ready;
    assign w_mispredict = w_commit && w_head.is_jump && (w_head.taken != w_head.pred_taken);

    // Control state: pointers, count, entry flags and registered commit-side outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) r_flags[i] <= '0;
            r_commit_valid   <= 1'b0;
            r_commit_id      <= '0;
            r_commit_rd      <= '0;
            r_commit_data    <= '0;
            r_commit_store   <= 1'b0;
            r_pred_upd_valid <= 1'b0;
            r_pred_upd_taken <= 1'b0;
            r_pred_upd_pc    <= '0;
            r_flush          <= 1'b0;
            r_flush_pc       <= '0;
        end else if (rdy_in) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid_in[k] && r_flags[cdb_id_in[k*ROB_W +: ROB_W]].busy) begin
                    r_flags[cdb_id_in[k*ROB_W +: ROB_W]].ready <= 1'b1;
                    r_flags[cdb_id_in[k*ROB_W +: ROB_W]].taken <= cdb_taken_in[k];
                end
            end
            if (w_commit) r_flags[r_head].busy <= 1'b0;
            if (w_alloc) begin
                r_flags[r_tail] <= '{busy: 1'b1, ready: 1'b0, is_jump: alloc_is_jump_in,
                                     is_store: alloc_is_store_in,
                                     pred_taken: alloc_pred_taken_in, taken: 1'b0};
            end
            // Later assignments win: a flush discards this cycle's alloc and writebacks.
            if (w_mispredict) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    r_flags[i].busy  <= 1'b0;
                    r_flags[i].ready <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + ROB_W'(w_commit);
                r_tail  <= r_tail + ROB_W'(w_alloc);
                r_count <= r_count + (ROB_W+1)'(w_alloc) - (ROB_W+1)'(w_commit);
            end

            r_commit_valid   <= w_commit;
            r_commit_store   <= w_commit && w_head.is_store;
            r_pred_upd_valid <= w_commit && w_head.is_jump;
            r_flush          <= w_mispredict;
            if (w_commit) begin
                r_commit_id   <= r_head;
                r_commit_rd   <= r_rd[r_head];
                r_commit_data <= r_data[r_head];
            end
            if (w_commit && w_head.is_jump) begin
                r_pred_upd_taken <= w_head.taken;
                r_pred_upd_pc    <= r_pc[r_head];
            end
            if (w_mispredict) r_flush_pc <= r_rb_pc[r_head];
        end else begin
            r_commit_valid   <= 1'b0;
            r_commit_store   <= 1'b0;
            r_pred_upd_valid <= 1'b0;
            r_flush          <= 1'b0;
        end
    end

    // Payload needs no reset; it is only consumed behind busy/ready.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (w_alloc) begin
                r_rd[r_tail]    <= alloc_rd_in;
                r_pc[r_tail]    <= alloc_pc_in;
                r_rb_pc[r_tail] <= alloc_rollback_pc_in;
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid_in[k] && r_flags[cdb_id_in[k*ROB_W +: ROB_W]].busy) begin
                    r_data[cdb_id_in[k*ROB_W +: ROB_W]] <= cdb_data_in[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    rob_cdb_bypass #(
        .NUM_CDB (NUM_CDB),
        .ROB_W   (ROB_W),
        .DATA_W  (DATA_W)
    ) u_bypass_q1 (
        .i_q_id        (q1_id_in),
        .i_cdb_valid   (cdb_valid_in),
        .i_cdb_id      (cdb_id_in),
        .i_cdb_data    (cdb_data_in),
        .i_entry_ready (r_flags[q1_id_in].ready),
        .i_entry_data  (r_data[q1_id_in]),
        .o_rdy         (q1_rdy_out),
        .o_data        (q1_data_out)
    );

    rob_cdb_bypass #(
        .NUM_CDB (NUM_CDB),
        .ROB_W   (ROB_W),
        .DATA_W  (DATA_W)
    ) u_bypass_q2 (
        .i_q_id        (q2_id_in),
        .i_cdb_valid   (cdb_valid_in),
        .i_cdb_id      (cdb_id_in),
        .i_cdb_data    (cdb_data_in),
        .i_entry_ready (r_flags[q2_id_in].ready),
        .i_entry_data  (r_data[q2_id_in]),
        .o_rdy         (q2_rdy_out),
        .o_data        (q2_data_out)
    );

    assign alloc_id_out       = r_tail;
    assign full_out           = w_full;
    assign commit_valid_out   = r_commit_valid;
    assign commit_id_out      = r_commit_id;
    assign commit_rd_out      = r_commit_rd;
    assign commit_data_out    = r_commit_data;
    assign commit_store_out   = r_commit_store;
    assign pred_upd_valid_out = r_pred_upd_valid;
    assign pred_upd_taken_out = r_pred_upd_taken;
    assign pred_upd_pc_out    = r_pred_upd_pc;
    assign flush_out          = r_flush;
    assign flush_pc_out       = r_flush_pc;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc: a queue-based ROB model predicts commits,
// a separate monitor pops and compares them.
module tb_reorder_buffer_mc;

    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        alloc_valid_in;
    logic [4:0]  alloc_rd_in;
    logic        alloc_is_jump_in;
    logic        alloc_is_store_in;
    logic        alloc_pred_taken_in;
    logic [31:0] alloc_pc_in;
    logic [31:0] alloc_rollback_pc_in;
    logic [3:0]  alloc_id_out;
    logic        full_out;
    logic [3:0]  q1_id_in, q2_id_in;
    logic        q1_rdy_out, q2_rdy_out;
    logic [31:0] q1_data_out, q2_data_out;
    logic [1:0]  cdb_valid_in;
    logic [7:0]  cdb_id_in;
    logic [63:0] cdb_data_in;
    logic [1:0]  cdb_taken_in;
    logic        commit_valid_out;
    logic [3:0]  commit_id_out;
    logic [4:0]  commit_rd_out;
    logic [31:0] commit_data_out;
    logic        commit_store_out;
    logic        pred_upd_valid_out;
    logic        pred_upd_taken_out;
    logic [31:0] pred_upd_pc_out;
    logic        flush_out;
    logic [31:0] flush_pc_out;

    reorder_buffer_mc dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
        .alloc_is_jump_in(alloc_is_jump_in), .alloc_is_store_in(alloc_is_store_in),
        .alloc_pred_taken_in(alloc_pred_taken_in), .alloc_pc_in(alloc_pc_in),
        .alloc_rollback_pc_in(alloc_rollback_pc_in), .alloc_id_out(alloc_id_out),
        .full_out(full_out), .q1_id_in(q1_id_in), .q2_id_in(q2_id_in),
        .q1_rdy_out(q1_rdy_out), .q2_rdy_out(q2_rdy_out),
        .q1_data_out(q1_data_out), .q2_data_out(q2_data_out),
        .cdb_valid_in(cdb_valid_in), .cdb_id_in(cdb_id_in), .cdb_data_in(cdb_data_in),
        .cdb_taken_in(cdb_taken_in), .commit_valid_out(commit_valid_out),
        .commit_id_out(commit_id_out), .commit_rd_out(commit_rd_out),
        .commit_data_out(commit_data_out), .commit_store_out(commit_store_out),
        .pred_upd_valid_out(pred_upd_valid_out), .pred_upd_taken_out(pred_upd_taken_out),
        .pred_upd_pc_out(pred_upd_pc_out), .flush_out(flush_out), .flush_pc_out(flush_pc_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic        jmp, st, pred, ready, taken;
        logic [31:0] pc, rb, data;
    } ent_t;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] data, pc, rb;
        logic        st, jmp, taken, flush;
    } exp_t;

    ent_t rob[$];
    exp_t expq[$];
    int   m_tail;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Stimulus for the next cycle
    logic        s_rdy, s_alloc, s_jump, s_store, s_pred;
    logic [4:0]  s_rd;
    logic [31:0] s_pc, s_rb;
    logic [1:0]  s_cv, s_ctaken;
    logic [3:0]  s_cid [2];
    logic [31:0] s_cdata [2];
    logic [3:0]  s_q1, s_q2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int find_id(input int id);
        foreach (rob[i]) if (rob[i].id == id) return i;
        return -1;
    endfunction

    task automatic check_lookup(input string name, input logic [3:0] q, input logic act_rdy,
                                input logic [31:0] act_data);
        bit known = 0;
        logic er = 1'b0;
        logic [31:0] ed = '0;
        int idx;
        for (int k = 0; k < 2; k++) begin
            if (!known && s_cv[k] && s_cid[k] == q) begin
                known = 1; er = 1'b1; ed = s_cdata[k];
            end
        end
        if (!known) begin
            idx = find_id(int'(q));
            if (idx >= 0) begin
                known = 1; er = rob[idx].ready; ed = er ? rob[idx].data : 32'h0;
            end
        end
        if (known) begin
            chk({name, "_rdy"}, act_rdy, er);
            chk({name, "_data"}, act_data, ed);
        end
    endtask

    task automatic clear_stim();
        s_rdy = 1'b1; s_alloc = 1'b0; s_jump = 1'b0; s_store = 1'b0; s_pred = 1'b0;
        s_rd = '0; s_pc = '0; s_rb = '0; s_cv = '0; s_ctaken = '0;
        s_cid[0] = '0; s_cid[1] = '0; s_cdata[0] = '0; s_cdata[1] = '0;
        s_q1 = '0; s_q2 = '0;
    endtask

    task automatic rand_stim();
        int pend[$];
        int j, id;
        s_rdy   = ($urandom_range(0, 9) != 0);
        s_alloc = ($urandom_range(0, 9) < 6);
        s_rd    = 5'($urandom);
        s_jump  = ($urandom_range(0, 7) == 0);
        s_store = !s_jump && ($urandom_range(0, 4) == 0);
        s_pred  = 1'($urandom);
        s_pc    = $urandom;
        s_rb    = $urandom;
        s_cv    = '0;
        foreach (rob[i]) if (!rob[i].ready) pend.push_back(rob[i].id);
        for (int k = 0; k < 2; k++) begin
            s_cdata[k]  = $urandom;
            s_ctaken[k] = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if (pend.size() > 0) begin
                    j = $urandom_range(0, pend.size() - 1);
                    s_cid[k] = 4'(pend[j]);
                    pend.delete(j);
                    s_cv[k] = 1'b1;
                end else if ($urandom_range(0, 3) == 0) begin
                    id = $urandom_range(0, DEPTH - 1);
                    if (find_id(id) < 0 && (k == 0 || !s_cv[0] || s_cid[0] != 4'(id))) begin
                        s_cid[k] = 4'(id);
                        s_cv[k]  = 1'b1;
                    end
                end
            end
        end
        s_q1 = (s_cv[0] && $urandom_range(0, 1) == 1) ? s_cid[0] : 4'($urandom);
        s_q2 = (s_cv[1] && $urandom_range(0, 1) == 1) ? s_cid[1] : 4'($urandom);
    endtask

    // Called at a negedge: drive, check combinational outputs, advance the model, wait one cycle.
    task automatic do_cycle();
        bit   full_pre, fl;
        exp_t e;
        ent_t n;
        int   idx;
        rdy_in               = s_rdy;
        alloc_valid_in       = s_alloc;
        alloc_rd_in          = s_rd;
        alloc_is_jump_in     = s_jump;
        alloc_is_store_in    = s_store;
        alloc_pred_taken_in  = s_pred;
        alloc_pc_in          = s_pc;
        alloc_rollback_pc_in = s_rb;
        cdb_valid_in         = s_cv;
        cdb_id_in            = {s_cid[1], s_cid[0]};
        cdb_data_in          = {s_cdata[1], s_cdata[0]};
        cdb_taken_in         = s_ctaken;
        q1_id_in             = s_q1;
        q2_id_in             = s_q2;
        #1;
        chk("alloc_id", alloc_id_out, m_tail);
        chk("full", full_out, rob.size() == DEPTH);
        check_lookup("q1", s_q1, q1_rdy_out, q1_data_out);
        check_lookup("q2", s_q2, q2_rdy_out, q2_data_out);
        if (s_rdy) begin
            full_pre = (rob.size() == DEPTH);
            fl = 0;
            if (rob.size() > 0 && rob[0].ready) begin
                fl = rob[0].jmp && (rob[0].taken != rob[0].pred);
                e.id = rob[0].id; e.rd = rob[0].rd; e.data = rob[0].data; e.st = rob[0].st;
                e.jmp = rob[0].jmp; e.taken = rob[0].taken; e.pc = rob[0].pc; e.rb = rob[0].rb;
                e.flush = fl;
                expq.push_back(e);
                void'(rob.pop_front());
            end
            for (int k = 0; k < 2; k++) begin
                if (s_cv[k]) begin
                    idx = find_id(int'(s_cid[k]));
                    if (idx >= 0) begin
                        rob[idx].ready = 1'b1;
                        rob[idx].data  = s_cdata[k];
                        rob[idx].taken = s_ctaken[k];
                    end
                end
            end
            if (s_alloc && !full_pre) begin
                n.id = m_tail; n.rd = s_rd; n.jmp = s_jump; n.st = s_store; n.pred = s_pred;
                n.pc = s_pc; n.rb = s_rb; n.ready = 1'b0; n.data = '0; n.taken = 1'b0;
                rob.push_back(n);
                m_tail = (m_tail + 1) % DEPTH;
            end
            if (fl) begin
                rob.delete();
                m_tail = 0;
            end
        end
        @(negedge clk_in);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {commit_valid_out, commit_id_out, commit_rd_out, commit_store_out,
                             pred_upd_valid_out, pred_upd_taken_out, flush_out, alloc_id_out,
                             full_out}, '0);
        chk({tag, "_pc"}, {pred_upd_pc_out, flush_pc_out}, '0);
        chk({tag, "_data"}, commit_data_out, '0);
    endtask

    // Monitor: compare every presented commit against the oldest expected one.
    exp_t me;
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (commit_valid_out) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got id %0d, expected no commit",
                             commit_id_out);
                end else begin
                    me = expq.pop_front();
                    chk("commit_id", commit_id_out, me.id);
                    chk("commit_rd", commit_rd_out, me.rd);
                    chk("commit_data", commit_data_out, me.data);
                    chk("commit_store", commit_store_out, me.st);
                    chk("pred_upd_valid", pred_upd_valid_out, me.jmp);
                    if (me.jmp) begin
                        chk("pred_upd_taken", pred_upd_taken_out, me.taken);
                        chk("pred_upd_pc", pred_upd_pc_out, me.pc);
                    end
                    chk("flush", flush_out, me.flush);
                    if (me.flush) chk("flush_pc", flush_pc_out, me.rb);
                end
            end else begin
                chk("idle_pulses", {commit_store_out, pred_upd_valid_out, flush_out}, '0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int br;
        m_tail = 0;
        clear_stim();
        rst_in = 1'b0;
        rdy_in = 1'b1; alloc_valid_in = 1'b0; alloc_rd_in = '0; alloc_is_jump_in = 1'b0;
        alloc_is_store_in = 1'b0; alloc_pred_taken_in = 1'b0; alloc_pc_in = '0;
        alloc_rollback_pc_in = '0; q1_id_in = '0; q2_id_in = '0; cdb_valid_in = '0;
        cdb_id_in = '0; cdb_data_in = '0; cdb_taken_in = '0;
        repeat (2) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b1;

        // Fill to full; the 17th request is refused.
        for (int i = 0; i < DEPTH + 1; i++) begin
            clear_stim(); s_alloc = 1'b1; s_rd = 5'(i); s_pc = 32'(i * 4); s_q1 = 4'(i);
            do_cycle();
        end
        clear_stim(); do_cycle();
        clear_stim(); s_alloc = 1'b1; s_cv = 2'b01; s_cid[0] = 4'd0; s_cdata[0] = 32'hCAFE;
        do_cycle();
        // Commit and alloc together while full: alloc still refused.
        clear_stim(); s_alloc = 1'b1; do_cycle();
        clear_stim(); do_cycle();

        repeat (1500) begin rand_stim(); do_cycle(); end

        // Mid-stream reset with live entries.
        repeat (6) begin clear_stim(); s_alloc = 1'b1; do_cycle(); end
        alloc_valid_in = 1'b0; cdb_valid_in = '0;
        rst_in = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        chk("mid_reset_q1_rdy", {q1_rdy_out, q2_rdy_out}, 2'b00);
        rob.delete();
        m_tail = 0;
        @(negedge clk_in);
        rst_in = 1'b1;

        // Out-of-order writeback, in-order commit.
        clear_stim(); s_alloc = 1'b1; s_rd = 5'd1; do_cycle();
        clear_stim(); s_alloc = 1'b1; s_rd = 5'd2; do_cycle();
        clear_stim(); s_cv = 2'b10; s_cid[1] = 4'd1; s_cdata[1] = 32'h55; s_q1 = 4'd1; do_cycle();
        clear_stim(); s_cv = 2'b01; s_cid[0] = 4'd0; s_cdata[0] = 32'hAA; s_q2 = 4'd1; do_cycle();
        clear_stim(); s_cv = 2'b01; s_cid[0] = 4'd3; s_cdata[0] = 32'h1234; s_q1 = 4'd3; do_cycle();
        clear_stim(); repeat (2) do_cycle();

        // Mispredicted branch with three younger entries.
        br = m_tail;
        clear_stim(); s_alloc = 1'b1; s_jump = 1'b1; s_pred = 1'b1; s_rd = 5'd7;
        s_pc = 32'h100; s_rb = 32'h104; do_cycle();
        clear_stim(); s_alloc = 1'b1; repeat (3) do_cycle();
        clear_stim(); s_cv = 2'b01; s_cid[0] = 4'(br); s_cdata[0] = 32'h108; s_ctaken = 2'b00;
        do_cycle();
        clear_stim(); s_alloc = 1'b1; s_cv = 2'b01; s_cid[0] = 4'(br + 1); s_cdata[0] = 32'h9;
        do_cycle();
        clear_stim(); do_cycle();

        repeat (1500) begin rand_stim(); do_cycle(); end

        clear_stim(); do_cycle();
        chk("scoreboard_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
